// File: rtl/cci_mpf_shim_tx_fifo_pkg.sv
// cci_mpf_shim_tx_fifo_pkg: shared sizing types and helpers for the per-channel Tx request FIFOs
package cci_mpf_shim_tx_fifo_pkg;

    localparam int TX_FIFO_DEPTH = 64;

    // Pointer width for a FIFO of the given depth (depth is a power of 2)
    function automatic int tx_fifo_idx_bits(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: must hold the value depth itself
    function automatic int tx_fifo_cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bit offset of channel i inside a flattened payload bus
    function automatic int tx_fifo_slice(input int i, input int width);
        return i * width;
    endfunction

    typedef logic [tx_fifo_idx_bits(TX_FIFO_DEPTH)-1:0] t_tx_fifo_idx;
    typedef logic [tx_fifo_cnt_bits(TX_FIFO_DEPTH)-1:0] t_tx_fifo_cnt;

endpackage

// File: rtl/cci_mpf_shim_tx_chan_fifo.sv
// cci_mpf_shim_tx_chan_fifo: single-channel request FIFO with registered issue, almost-full,
// sticky overflow and an optional high-water mark (CCI_MPF_SHIM_TX_FIFO_HWM_EN).
module cci_mpf_shim_tx_chan_fifo
    import cci_mpf_shim_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 600,
    parameter int DEPTH          = 64,
    parameter int ALM_FULL_SLACK = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enq_valid,
    input  logic [DATA_WIDTH-1:0]                enq_data,
    output logic                                 alm_full,
    output logic                                 deq_valid,
    output logic [DATA_WIDTH-1:0]                deq_data,
    input  logic                                 deq_alm_full,
    output logic                                 overflow_err,
    output logic [tx_fifo_cnt_bits(DEPTH)-1:0]   hwm
);

    localparam int IW = tx_fifo_idx_bits(DEPTH);
    localparam int CW = tx_fifo_cnt_bits(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    // free <= slack is the same as count >= DEPTH - slack
    localparam logic [CW-1:0] ALM_LEVEL = CW'(DEPTH - ALM_FULL_SLACK);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         head;
    logic [IW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  issue;
    logic                  enq;

    // Issue/enqueue decisions; a pop in the same edge frees a slot, so a full FIFO still accepts
    always_comb begin
        issue      = (count != '0) && !deq_alm_full;
        enq        = enq_valid && ((count != FULL) || issue);
        count_next = count + CW'(enq) - CW'(issue);
    end

    // Payload storage, no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= enq_data;
    end

    // Pointers, count, registered issue and flow-control flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            deq_valid    <= 1'b0;
            deq_data     <= '0;
            alm_full     <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            head         <= head + IW'(issue);
            tail         <= tail + IW'(enq);
            count        <= count_next;
            deq_valid    <= issue;
            if (issue) deq_data <= mem[head];
            alm_full     <= count_next >= ALM_LEVEL;
            overflow_err <= overflow_err | (enq_valid & ~enq);
        end
    end

`ifdef CCI_MPF_SHIM_TX_FIFO_HWM_EN
    // Track peak occupancy after each edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hwm <= '0;
        else if (count_next > hwm) hwm <= count_next;
    end
`else
    assign hwm = '0;
`endif

endmodule

// File: rtl/cci_mpf_shim_tx_fifo.sv
// cci_mpf_shim_tx_fifo: N independent Tx request buffers between AFU and FIU MPF ports.
// Optional per-channel high-water mark enabled by CCI_MPF_SHIM_TX_FIFO_HWM_EN.
module cci_mpf_shim_tx_fifo
    import cci_mpf_shim_tx_fifo_pkg::*;
#(
    parameter int N_CHANNELS     = 2,
    parameter int DATA_WIDTH     = 600,
    parameter int DEPTH          = 64,
    parameter int ALM_FULL_SLACK = 8
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [N_CHANNELS-1:0]                     afu_tx_valid,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]          afu_tx_data,
    output logic [N_CHANNELS-1:0]                     afu_alm_full,
    output logic [N_CHANNELS-1:0]                     fiu_tx_valid,
    output logic [N_CHANNELS*DATA_WIDTH-1:0]          fiu_tx_data,
    input  logic [N_CHANNELS-1:0]                     fiu_alm_full,
    output logic [N_CHANNELS-1:0]                     overflow_err,
    output logic [N_CHANNELS*$clog2(DEPTH+1)-1:0]     hwm
);

    localparam int CW = tx_fifo_cnt_bits(DEPTH);

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        cci_mpf_shim_tx_chan_fifo #(
            .DATA_WIDTH     (DATA_WIDTH),
            .DEPTH          (DEPTH),
            .ALM_FULL_SLACK (ALM_FULL_SLACK)
        ) chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .enq_valid    (afu_tx_valid[g]),
            .enq_data     (afu_tx_data[tx_fifo_slice(g, DATA_WIDTH) +: DATA_WIDTH]),
            .alm_full     (afu_alm_full[g]),
            .deq_valid    (fiu_tx_valid[g]),
            .deq_data     (fiu_tx_data[tx_fifo_slice(g, DATA_WIDTH) +: DATA_WIDTH]),
            .deq_alm_full (fiu_alm_full[g]),
            .overflow_err (overflow_err[g]),
            .hwm          (hwm[g*CW +: CW])
        );
    end

endmodule

// File: tb/tb_cci_mpf_shim_tx_fifo.sv
// tb_cci_mpf_shim_tx_fifo: directed bench with a channel-0 scoreboard and idle checks on channel 1
module tb_cci_mpf_shim_tx_fifo;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int S  = 4;
    localparam int CW = $clog2(D + 1);
`ifdef CCI_MPF_SHIM_TX_FIFO_HWM_EN
    localparam int HWM_EXP = 9;
`else
    localparam int HWM_EXP = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   afu_tx_valid = '0;
    logic [N*W-1:0] afu_tx_data = '0;
    logic [N-1:0]   fiu_alm_full = '0;
    logic [N-1:0]   afu_alm_full;
    logic [N-1:0]   fiu_tx_valid;
    logic [N*W-1:0] fiu_tx_data;
    logic [N-1:0]   overflow_err;
    logic [N*CW-1:0] hwm;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    // expected channel-0 state after the most recent edge
    int         m_cnt;
    logic [W-1:0] q[$];
    logic       m_valid, m_af, m_af1, m_ovf;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    cci_mpf_shim_tx_fifo #(
        .N_CHANNELS     (N),
        .DATA_WIDTH     (W),
        .DEPTH          (D),
        .ALM_FULL_SLACK (S)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .afu_tx_valid (afu_tx_valid),
        .afu_tx_data  (afu_tx_data),
        .afu_alm_full (afu_alm_full),
        .fiu_tx_valid (fiu_tx_valid),
        .fiu_tx_data  (fiu_tx_data),
        .fiu_alm_full (fiu_alm_full),
        .overflow_err (overflow_err),
        .hwm          (hwm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_cnt = 0;
        q.delete();
        m_valid = 1'b0;
        m_af = 1'b1;
        m_af1 = 1'b1;
        m_ovf = 1'b0;
        m_data = '0;
    endtask

    // Scoreboard: inputs are stable across the negedge and the next posedge, so the model
    // checks the last edge's outputs, then predicts the next edge from the current inputs.
    initial begin
        bit iss, enq;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            if (fiu_tx_valid[0] === 1'b1) pulses++;
            chk("valid0", 64'(fiu_tx_valid[0]), 64'(m_valid));
            if (m_valid) chk("data0", 64'(fiu_tx_data[W-1:0]), 64'(m_data));
            chk("alm_full0", 64'(afu_alm_full[0]), 64'(m_af));
            chk("ovf0", 64'(overflow_err[0]), 64'(m_ovf));
            chk("ch1_idle", 64'({fiu_tx_valid[1], overflow_err[1]}), 64'(0));
            chk("alm_full1", 64'(afu_alm_full[1]), 64'(m_af1));
            if (reset_n) begin
                iss = (m_cnt != 0) && !fiu_alm_full[0];
                enq = afu_tx_valid[0] && ((m_cnt != D) || iss);
                if (afu_tx_valid[0] && !enq) m_ovf = 1'b1;
                m_valid = iss;
                if (iss) m_data = q.pop_front();
                if (enq) q.push_back(afu_tx_data[W-1:0]);
                m_cnt = m_cnt + int'(enq) - int'(iss);
                m_af = (D - m_cnt) <= S;
                m_af1 = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk("rst_alm_full", 64'(afu_alm_full), 64'(2'b11));
        chk("rst_valid", 64'(fiu_tx_valid), 64'(0));
        chk("rst_ovf", 64'(overflow_err), 64'(0));
        chk("rst_hwm", 64'(hwm), 64'(0));
        reset_n = 1'b1;
        tick();
        chk("alm_full_release", 64'(afu_alm_full), 64'(0));

        // back-to-back throughput, FIU open
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h1000 + i);
            tick();
            if (i == 0) chk("lat_first_edge", 64'(fiu_tx_valid[0]), 64'(0));
            if (i == 1) chk("lat_next_edge", 64'({fiu_tx_valid[0], fiu_tx_data[W-1:0]}), 64'({1'b1, 16'h1000}));
        end
        afu_tx_valid[0] = 1'b0;
        repeat (3) tick();
        chk("thru_pulses", 64'(pulses - p0), 64'(10));

        // backpressure fill of 12, then release
        fiu_alm_full[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h2000 + i);
            tick();
            if (i == 10) chk("bp_af_at11", 64'(afu_alm_full[0]), 64'(0));
            if (i == 11) chk("bp_af_at12", 64'(afu_alm_full[0]), 64'(1));
        end
        afu_tx_valid[0] = 1'b0;
        chk("bp_held", 64'(fiu_tx_valid[0]), 64'(0));
        fiu_alm_full[0] = 1'b0;
        p0 = pulses;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("bp_burst", 64'(fiu_tx_valid[0]), 64'(1));
        end
        tick();
        chk("bp_burst_end", 64'(fiu_tx_valid[0]), 64'(0));
        repeat (2) tick();
        chk("bp_pulses", 64'(pulses - p0), 64'(12));

        // full FIFO with a simultaneous enqueue and dequeue
        fiu_alm_full[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h3000 + i);
            tick();
        end
        chk("full_af", 64'(afu_alm_full[0]), 64'(1));
        fiu_alm_full[0] = 1'b0;
        afu_tx_data[W-1:0] = 16'h30ff;
        p0 = pulses;
        tick();
        afu_tx_valid[0] = 1'b0;
        chk("full_swap_ovf", 64'(overflow_err[0]), 64'(0));
        chk("full_swap_af", 64'(afu_alm_full[0]), 64'(1));
        repeat (20) tick();
        chk("full_swap_pulses", 64'(pulses - p0), 64'(17));

        // overflow: 17 requests into 16 entries
        fiu_alm_full[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h4000 + i);
            tick();
            if (i == 15) chk("ovf_not_yet", 64'(overflow_err[0]), 64'(0));
        end
        afu_tx_valid[0] = 1'b0;
        chk("ovf_set", 64'(overflow_err[0]), 64'(1));
        fiu_alm_full[0] = 1'b0;
        p0 = pulses;
        repeat (20) tick();
        chk("ovf_pulses", 64'(pulses - p0), 64'(16));
        chk("ovf_sticky", 64'(overflow_err[0]), 64'(1));

        // asynchronous reset with requests in flight
        fiu_alm_full[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h5000 + i);
            tick();
        end
        afu_tx_valid[0] = 1'b0;
        fiu_alm_full[0] = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(fiu_tx_valid[0]), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(fiu_tx_valid), 64'(0));
        chk("async_af", 64'(afu_alm_full), 64'(2'b11));
        chk("async_ovf", 64'(overflow_err), 64'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        p0 = pulses;
        tick();
        chk("post_rst_af", 64'(afu_alm_full), 64'(0));
        chk("post_rst_hwm", 64'(hwm), 64'(0));
        repeat (6) tick();
        chk("no_stale", 64'(pulses - p0), 64'(0));

        // high-water mark: fill to 9, then drain
        fiu_alm_full[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[W-1:0] = W'(16'h6000 + i);
            tick();
        end
        afu_tx_valid[0] = 1'b0;
        fiu_alm_full[0] = 1'b0;
        repeat (12) tick();
        chk("hwm0", 64'(hwm[CW-1:0]), 64'(HWM_EXP));
        chk("hwm1", 64'(hwm[2*CW-1:CW]), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
